// File: rtl/classifier_arbiter_if.sv
// Purpose: bundles the requester-side and classifier-side signals of classifier_arbiter.
// Latency: none (wires only).
// Backpressure: none here; cls_ready gates new jobs inside the arbiter.
interface classifier_arbiter_if #(
  parameter int N_REQ = 4
);
  // requester side
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] pix_data;
  logic [N_REQ-1:0]   pix_valid;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   resp_valid;
  logic [1:0]         resp_class;
  logic               resp_err;
  logic               busy;
  logic [7:0]         err_count;
  // classifier side
  logic               cls_start;
  logic               cls_ready;
  logic               cls_done;
  logic [1:0]         cls_class;
  logic [7:0]         cls_pixel;
  logic               cls_pixel_valid;

  // Environment view: requesters plus the classifier model
  modport master (
    output req, pix_data, pix_valid, cls_ready, cls_done, cls_class,
    input  grant, resp_valid, resp_class, resp_err, busy, err_count,
           cls_start, cls_pixel, cls_pixel_valid
  );

  // Arbiter view
  modport slave (
    input  req, pix_data, pix_valid, cls_ready, cls_done, cls_class,
    output grant, resp_valid, resp_class, resp_err, busy, err_count,
           cls_start, cls_pixel, cls_pixel_valid
  );
endinterface

// File: rtl/classifier_arbiter.sv
// Purpose: round-robin sharing of one classifier among N_REQ requesters, with a job watchdog.
// Latency: req sampled at edge k -> grant/cls_start in cycle k+1; resp_valid the cycle after cls_done.
// Backpressure: no grant while cls_ready=0; requesters hold req until resp_valid, non-owner pixels dropped.
module classifier_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  classifier_arbiter_if.slave bus
);

  localparam int IDW = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   ptr_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] resp_valid_q;
  logic [WDW-1:0]   wd_q;
  logic [1:0]       class_q;
  logic             err_q;
  logic             busy_q;
  logic             start_q;
  logic [7:0]       err_count_q;

  logic             pick_vld;
  logic [IDW-1:0]   pick_id;
  int               idx;
  logic [IDW-1:0]   idx_w;

  // Round-robin search: first asserted req after ptr, wrapping. Scanning from the
  // far end down lets the nearest candidate overwrite earlier hits.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    idx_w    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = IDW'(idx);
      if (bus.req[idx_w]) begin
        pick_vld = 1'b1;
        pick_id  = idx_w;
      end
    end
  end

  // Job FSM; every externally visible control output is a register updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      id_q         <= '0;
      ptr_q        <= IDW'(N_REQ - 1);
      grant_q      <= '0;
      resp_valid_q <= '0;
      wd_q         <= '0;
      class_q      <= 2'd0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      start_q      <= 1'b0;
      resp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_vld && bus.cls_ready) begin
            id_q    <= pick_id;
            grant_q <= N_REQ'(1) << pick_id;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          wd_q    <= '0;
          state_q <= RUN;
        end
        RUN: begin
          wd_q <= wd_q + 1'b1;
          // a done arriving on the timeout cycle still delivers a real result
          if (bus.cls_done) begin
            class_q      <= bus.cls_class;
            err_q        <= 1'b0;
            resp_valid_q <= grant_q;
            state_q      <= RESP;
          end else if (wd_q == WDW'(TIMEOUT - 1)) begin
            class_q      <= 2'd0;
            err_q        <= 1'b1;
            resp_valid_q <= grant_q;
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          ptr_q   <= id_q;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pixel path: only the owner's stream reaches the classifier, and only in RUN
  always_comb begin
    bus.cls_pixel       = 8'd0;
    bus.cls_pixel_valid = 1'b0;
    if (state_q == RUN) begin
      bus.cls_pixel       = bus.pix_data[{id_q, 3'b000} +: 8];
      bus.cls_pixel_valid = bus.pix_valid[id_q];
    end
  end

  assign bus.grant      = grant_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_class = class_q;
  assign bus.resp_err   = err_q;
  assign bus.busy       = busy_q;
  assign bus.cls_start  = start_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_classifier_arbiter.sv
// Purpose: self-checking bench for classifier_arbiter with a response scoreboard.
// Latency: drives and samples on the falling edge, away from the active edge.
// Backpressure: exercises cls_ready=0 stalls, dropped requests and watchdog aborts.
module tb_classifier_arbiter;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  classifier_arbiter_if #(.N_REQ(N_REQ)) bus ();

  classifier_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         id;
    logic [1:0] cls;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   exp_errcnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expected job
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.resp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'(bus.resp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_resp_valid", 32'(bus.resp_valid), 32'(1) << mon_e.id);
        chk("sb_resp_class", 32'(bus.resp_class), 32'(mon_e.cls));
        chk("sb_resp_err",   32'(bus.resp_err),   32'(mon_e.err));
      end
    end
  end

  // One full job; entered at the falling edge of an IDLE cycle.
  // done_at < 0 means the classifier never answers.
  task automatic do_job(input logic [3:0] r, input int exp_id, input int done_at,
                        input logic [1:0] c, input bit drop_req, input bit release_req);
    int n;
    int last;
    bit e_err;
    exp_t e;
    logic [31:0] pd;
    bus.req       = r;
    bus.pix_valid = '1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.grant == '0 && n < 40);
    chk("grant", 32'(bus.grant), 32'(1) << exp_id);
    chk("grant_lat", 32'(n), 32'd1);
    chk("start_pulse", 32'(bus.cls_start), 32'd1);
    chk("busy_start", 32'(bus.busy), 32'd1);
    chk("pv_start", 32'(bus.cls_pixel_valid), 32'd0);
    e_err = (done_at < 0) || (done_at > TIMEOUT - 1);
    e.id  = exp_id;
    e.cls = e_err ? 2'd0 : c;
    e.err = e_err;
    sb.push_back(e);
    if (e_err) begin
      last = TIMEOUT - 1;
      exp_errcnt = (exp_errcnt < 255) ? exp_errcnt + 1 : 255;
    end else begin
      last = done_at;
    end
    if (drop_req) bus.req = '0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == 0) chk("start_once", 32'(bus.cls_start), 32'd0);
      if (k < 2) begin
        pd = $urandom;
        bus.pix_data  = pd;
        bus.pix_valid = (k == 0) ? (4'b0001 << exp_id) : ~(4'b0001 << exp_id);
        #1;
        chk("pix_route", 32'(bus.cls_pixel), 32'(pd[8*exp_id +: 8]));
        chk("pix_vld_route", 32'(bus.cls_pixel_valid), (k == 0) ? 32'd1 : 32'd0);
      end
      bus.cls_done  = (k == done_at);
      bus.cls_class = c;
    end
    @(negedge clk);
    bus.cls_done  = 1'b0;
    bus.pix_valid = '1;
    chk("resp_pulse", 32'(bus.resp_valid), 32'(1) << exp_id);
    chk("grant_resp", 32'(bus.grant), 32'(1) << exp_id);
    #1;
    chk("pv_resp", 32'(bus.cls_pixel_valid), 32'd0);
    if (release_req) bus.req = '0;
    @(negedge clk);
    chk("grant_clr", 32'(bus.grant), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("resp_once", 32'(bus.resp_valid), 32'd0);
    chk("errcnt", 32'(bus.err_count), 32'(exp_errcnt));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.pix_data  = '0;
    bus.pix_valid = '0;
    bus.cls_ready = 1'b1;
    bus.cls_done  = 1'b0;
    bus.cls_class = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_start", 32'(bus.cls_start), 32'd0);
    chk("rst_resp", 32'(bus.resp_valid), 32'd0);
    chk("rst_errcnt", 32'(bus.err_count), 32'd0);
    chk("rst_pv", 32'(bus.cls_pixel_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // all requesters held: fair rotation starting at requester 0
    do_job(4'b1111, 0, 5, 2'd1, 1'b0, 1'b0);
    do_job(4'b1111, 1, 5, 2'd2, 1'b0, 1'b0);
    do_job(4'b1111, 2, 5, 2'd3, 1'b0, 1'b0);
    do_job(4'b1111, 3, 5, 2'd0, 1'b0, 1'b0);
    do_job(4'b1111, 0, 5, 2'd1, 1'b0, 1'b1);

    // single requester, long job; owner drops req mid-job and is still answered
    do_job(4'b0001, 0, 19, 2'd2, 1'b1, 1'b1);

    // classifier not ready: no grant, stray pixel strobes and done ignored
    bus.cls_ready = 1'b0;
    bus.req       = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.pix_valid = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      bus.cls_done  = (i == 4);
      #1;
      chk("nr_grant", 32'(bus.grant), 32'd0);
      chk("nr_pv", 32'(bus.cls_pixel_valid), 32'd0);
    end
    bus.cls_done  = 1'b0;
    bus.cls_ready = 1'b1;
    do_job(4'b0010, 1, 3, 2'd3, 1'b0, 1'b1);

    // watchdog abort, then a normal job
    do_job(4'b1000, 3, -1, 2'd3, 1'b0, 1'b1);
    // done on the very cycle the watchdog expires: result wins
    do_job(4'b0001, 0, TIMEOUT - 1, 2'd2, 1'b0, 1'b1);

    // asynchronous reset in the middle of RUN
    bus.req = 4'b0001;
    @(negedge clk);
    chk("rr_grant", 32'(bus.grant), 32'd1);
    @(negedge clk);
    @(negedge clk);
    bus.pix_valid = '1;
    #1;
    chk("rr_pv_run", 32'(bus.cls_pixel_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", 32'(bus.grant), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_start", 32'(bus.cls_start), 32'd0);
    chk("ar_pv", 32'(bus.cls_pixel_valid), 32'd0);
    chk("ar_errcnt", 32'(bus.err_count), 32'd0);
    exp_errcnt = 0;
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    do_job(4'b0100, 2, 7, 2'd1, 1'b0, 1'b1);

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so a stuck design cannot hang the run
  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
